// File: rtl/fixed_point_pkg.sv
// ---------------------------------------------------------------------------
// fixed_point_pkg
//   Shared definitions for the fixed-point add arbiter:
//     state_t  - FSM state encoding (IDLE, EXEC, RESP)
//     sat_max  - largest signed value representable in 'width' bits
//     sat_min  - smallest signed value representable in 'width' bits
//   The limit functions return 32-bit signed values, so 'width' may be 2..31.
// ---------------------------------------------------------------------------
package fixed_point_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 16;

    function automatic logic signed [31:0] sat_max(input int width);
        return (32'sd1 <<< (width - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] sat_min(input int width);
        return -(32'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin search. The first set request found when
//   scanning upward from 'ptr' (wrapping past NREQ-1 back to 0) wins.
//   Ports:
//     req    [NREQ-1:0]  request vector
//     ptr    [PTR_W-1:0] index the search starts from (highest priority)
//     winner [NREQ-1:0]  one-hot winner, all zero when no request
//     valid              at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic             valid
);

    always_comb begin
        int idx;
        // NOTE: every signal written in this block gets a default first, so no
        // path through the loop can leave a value held (which would be a latch).
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_point_add_arbiter.sv
// ---------------------------------------------------------------------------
// fixed_point_add_arbiter
//   Shares one saturating signed adder between NREQ requesters. An idle cycle
//   with any request picks a winner round-robin and latches its operands; the
//   next cycle adds and clamps; the cycle after that presents the result with
//   a one-cycle done pulse. One operation per three cycles at most.
//   Ports:
//     i_clk, i_rst           clock, synchronous active-high reset
//     i_req      [NREQ]      request levels
//     i_operandA [NREQ*W]    signed operand A, slice k at [k*WIDTH +: WIDTH]
//     i_operandB [NREQ*W]    signed operand B, same slicing
//     i_clr_cnt              clears o_sat_count (wins over an increment)
//     o_gnt      [NREQ]      one-hot grant during EXEC and RESP
//     o_done     [NREQ]      one-hot, one-cycle completion pulse
//     o_val      [WIDTH]     saturated sum, held between operations
//     o_sat                  o_val was clamped
//     o_busy                 FSM not in IDLE
//     o_sat_count[16]        saturating count of clamped results
//   FBITS only documents the binary-point position; the adder is agnostic.
// ---------------------------------------------------------------------------
module fixed_point_add_arbiter
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 4,
    parameter int NREQ  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*WIDTH-1:0]  i_operandA,
    input  logic [NREQ*WIDTH-1:0]  i_operandB,
    input  logic                   i_clr_cnt,
    output logic [NREQ-1:0]        o_gnt,
    output logic [NREQ-1:0]        o_done,
    output logic [WIDTH-1:0]       o_val,
    output logic                   o_sat,
    output logic                   o_busy,
    output logic [CNT_W-1:0]       o_sat_count
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic signed [31:0] SAT_MAX = sat_max(WIDTH);
    localparam logic signed [31:0] SAT_MIN = sat_min(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_FULL = '1;

    state_t                   state;
    logic [PTR_W-1:0]         ptr;
    logic [PTR_W-1:0]         win_idx;
    logic signed [WIDTH-1:0]  op_a;
    logic signed [WIDTH-1:0]  op_b;

    logic [NREQ-1:0]          arb_winner;
    logic                     arb_valid;
    logic [PTR_W-1:0]         grant_idx;

    logic signed [WIDTH:0]    sum;
    logic signed [31:0]       sum_wide;
    logic [WIDTH-1:0]         clamp_val;
    logic                     clamp_flag;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req    (i_req),
        .ptr    (ptr),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // One-hot winner to binary index, used for operand selection and ptr.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_winner[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    // Sign-extend by one bit so the raw sum can never wrap, then clamp.
    assign sum      = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};
    assign sum_wide = 32'(sum);

    always_comb begin
        clamp_val  = sum[WIDTH-1:0];
        clamp_flag = 1'b0;
        if (sum_wide > SAT_MAX) begin
            clamp_val  = SAT_MAX[WIDTH-1:0];
            clamp_flag = 1'b1;
        end else if (sum_wide < SAT_MIN) begin
            clamp_val  = SAT_MIN[WIDTH-1:0];
            clamp_flag = 1'b1;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Operand and index registers are reset too; they are a few flops,
            // and a known value keeps the datapath deterministic after reset.
            state       <= IDLE;
            ptr         <= '0;
            win_idx     <= '0;
            op_a        <= '0;
            op_b        <= '0;
            o_gnt       <= '0;
            o_done      <= '0;
            o_val       <= '0;
            o_sat       <= 1'b0;
            o_busy      <= 1'b0;
            o_sat_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        win_idx <= grant_idx;
                        op_a    <= i_operandA[int'(grant_idx)*WIDTH +: WIDTH];
                        op_b    <= i_operandB[int'(grant_idx)*WIDTH +: WIDTH];
                        o_gnt   <= arb_winner;
                        o_busy  <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    o_val  <= clamp_val;
                    o_sat  <= clamp_flag;
                    o_done <= o_gnt;
                    state  <= RESP;
                end
                RESP: begin
                    o_done <= '0;
                    o_gnt  <= '0;
                    o_busy <= 1'b0;
                    ptr    <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // o_sat is only meaningful in RESP, where it belongs to this op.
            if (i_clr_cnt) begin
                o_sat_count <= '0;
            end else if (state == RESP && o_sat && o_sat_count != CNT_FULL) begin
                o_sat_count <= o_sat_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fixed_point_add_arbiter
//   Directed self-checking bench for fixed_point_add_arbiter with WIDTH=8,
//   FBITS=4, NREQ=4. Inputs change and outputs are sampled 1 time unit after
//   each rising edge.
// ---------------------------------------------------------------------------
module tb_fixed_point_add_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] operand_a;
    logic [NREQ*WIDTH-1:0] operand_b;
    logic                  clr_cnt;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      val;
    logic                  sat;
    logic                  busy;
    logic [15:0]           sat_count;

    int checks   = 0;
    int failures = 0;

    fixed_point_add_arbiter #(
        .WIDTH (8),
        .FBITS (4),
        .NREQ  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_operandA  (operand_a),
        .i_operandB  (operand_b),
        .i_clr_cnt   (clr_cnt),
        .o_gnt       (gnt),
        .o_done      (done),
        .o_val       (val),
        .o_sat       (sat),
        .o_busy      (busy),
        .o_sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},  32'(gnt),       32'h0);
        check({tag, "_done"}, 32'(done),      32'h0);
        check({tag, "_val"},  32'(val),       32'h0);
        check({tag, "_sat"},  32'(sat),       32'h0);
        check({tag, "_busy"}, 32'(busy),      32'h0);
        check({tag, "_cnt"},  32'(sat_count), 32'h0);
    endtask

    // One full operation for requester idx: raise its request, expect the
    // grant after one edge, done/result after two, and idle after three.
    // The request bit drops (and clr is applied) on the edge sampling done.
    task automatic do_op(input string tag, input int idx,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_val, input logic exp_sat,
                         input logic [15:0] exp_cnt, input logic clr);
        logic [NREQ-1:0] one_hot;
        one_hot = NREQ'(1) << idx;
        operand_a[idx*WIDTH +: WIDTH] = a;
        operand_b[idx*WIDTH +: WIDTH] = b;
        req[idx] = 1'b1;
        tick();
        check({tag, "_gnt"},   32'(gnt),  32'(one_hot));
        check({tag, "_busy"},  32'(busy), 32'h1);
        check({tag, "_nodone"}, 32'(done), 32'h0);
        tick();
        check({tag, "_done"},  32'(done), 32'(one_hot));
        check({tag, "_val"},   32'(val),  32'(exp_val));
        check({tag, "_sat"},   32'(sat),  32'(exp_sat));
        check({tag, "_gnt2"},  32'(gnt),  32'(one_hot));
        req[idx] = 1'b0;
        clr_cnt  = clr;
        tick();
        clr_cnt  = 1'b0;
        check({tag, "_done0"}, 32'(done), 32'h0);
        check({tag, "_gnt0"},  32'(gnt),  32'h0);
        check({tag, "_idle"},  32'(busy), 32'h0);
        check({tag, "_hold"},  32'(val),  32'(exp_val));
        check({tag, "_cnt"},   32'(sat_count), 32'(exp_cnt));
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        operand_a = '0;
        operand_b = '0;
        clr_cnt   = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Basic add: 1.5 + 1.0 = 2.5 in Q4.4.
        do_op("basic", 0, 8'h18, 8'h10, 8'h28, 1'b0, 16'd0, 1'b0);
        // Positive overflow clamps to 0x7F; negative overflow clamps to 0x80.
        do_op("pos_sat", 2, 8'h70, 8'h20, 8'h7F, 1'b1, 16'd1, 1'b0);
        do_op("neg_sat", 2, 8'h80, 8'hF0, 8'h80, 1'b1, 16'd2, 1'b0);

        // All four requesting after reset: served 0,1,2,3, three cycles apart.
        rst = 1'b1;
        tick();
        check_all_zero("reset2");
        rst = 1'b0;
        req = 4'b1111;
        do_op("rr0", 0, 8'h10, 8'h01, 8'h11, 1'b0, 16'd0, 1'b0);
        do_op("rr1", 1, 8'hF0, 8'h08, 8'hF8, 1'b0, 16'd0, 1'b0);
        do_op("rr2", 2, 8'h7F, 8'h00, 8'h7F, 1'b0, 16'd0, 1'b0);
        do_op("rr3", 3, 8'h30, 8'hF0, 8'h20, 1'b0, 16'd0, 1'b0);

        // req1 served (ptr -> 2), then req 0 and 1 pending: 0 wins by wrap.
        do_op("wrap_a", 1, 8'h7F, 8'h01, 8'h7F, 1'b1, 16'd1, 1'b0);
        req[1] = 1'b1;
        do_op("wrap_b", 0, 8'h08, 8'h08, 8'h10, 1'b0, 16'd1, 1'b0);
        do_op("wrap_c", 1, 8'hC0, 8'hC0, 8'h80, 1'b0, 16'd1, 1'b0);

        // Reset during EXEC: everything clears, no done, search restarts at 0.
        operand_a[3*WIDTH +: WIDTH] = 8'h11;
        operand_b[3*WIDTH +: WIDTH] = 8'h22;
        req = 4'b1000;
        tick();
        check("abort_gnt", 32'(gnt), 32'h8);
        rst = 1'b1;
        tick();
        check_all_zero("abort");
        rst    = 1'b0;
        req[1] = 1'b1;
        do_op("post_rst1", 1, 8'h01, 8'h02, 8'h03, 1'b0, 16'd0, 1'b0);
        do_op("post_rst3", 3, 8'h7F, 8'h7F, 8'h7F, 1'b1, 16'd1, 1'b0);

        // Reaching 0xFFFF by real saturations would take ~200k cycles, so the
        // counter is preloaded while idle, then driven to and held at full.
        force dut.o_sat_count = 16'hFFFE;
        #1;
        release dut.o_sat_count;
        do_op("cnt_full", 0, 8'h80, 8'h80, 8'h80, 1'b1, 16'hFFFF, 1'b0);
        do_op("cnt_hold", 0, 8'h80, 8'h80, 8'h80, 1'b1, 16'hFFFF, 1'b0);
        do_op("cnt_clr",  0, 8'h40, 8'h40, 8'h7F, 1'b1, 16'h0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
